// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the MIPS fetch pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          WORD_W     = 32;
    localparam logic [31:0] c_nop_word = 32'h0000_0000;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0]  c_op_rtype = 6'h00;
    localparam logic [5:0]  c_op_j     = 6'h02;
    localparam logic [5:0]  c_op_beq   = 6'h04;
    localparam logic [5:0]  c_op_lw    = 6'h23;
    localparam logic [5:0]  c_op_sw    = 6'h2B;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // What the next-PC selector decided for this cycle
    typedef enum logic [1:0] {
        NPC_HOLD     = 2'd0,
        NPC_SEQ      = 2'd1,
        NPC_REDIRECT = 2'd2
    } npc_kind_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem
//  Description : Word-organised instruction memory, combinational read by
//                byte address, synchronous write port for loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem
    import mips_pkg::*;
#(
    parameter int WORDS = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [31:0]              addr,
    output logic [31:0]              instr
);

    localparam int          AW      = $clog2(WORDS);
    localparam logic [31:0] c_limit = 32'(WORDS * 4);

    logic [31:0] r_mem [WORDS];

    // Load port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Illegal addresses read back as a NOP rather than aliasing
    always_comb begin
        instr = c_nop_word;
        if ((addr[1:0] == 2'b00) && (addr < c_limit)) begin
            instr = r_mem[addr[AW+1:2]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC mux (branch > jump > stall > PC+4)
//                plus legality check of the selected address.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 32
) (
    input  logic [31:0] pc,
    input  logic [3:0]  pc_region,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        stall,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output npc_kind_e   kind,
    output logic        illegal
);

    localparam logic [31:0] c_limit = 32'(IMEM_WORDS * 4);

    assign pc_plus4 = pc + 32'd4;

    // Priority select: the branch in EX is older than the jump in ID
    always_comb begin
        next_pc = pc;
        kind    = NPC_HOLD;
        if (branch_taken) begin
            next_pc = branch_target;
            kind    = NPC_REDIRECT;
        end else if (jump) begin
            next_pc = {pc_region, jump_index, 2'b00};
            kind    = NPC_REDIRECT;
        end else if (!stall) begin
            next_pc = pc_plus4;
            kind    = NPC_SEQ;
        end
    end

    // Only an address that is actually going to be loaded can fault
    assign illegal = (kind != NPC_HOLD) &&
                     ((next_pc[1:0] != 2'b00) || (next_pc >= c_limit));

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS instruction-fetch stage: PC register, IF/ID pipeline
//                register, BOOT/RUN/HALT control, sticky fault, fetch count.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_ifid_instr, w_ifid_instr_nxt;
    logic [31:0]  r_ifid_pc4, w_ifid_pc4_nxt;
    logic         r_ifid_valid, w_ifid_valid_nxt;
    logic         r_fault, w_fault_nxt;
    logic [31:0]  r_fetch_count, w_fetch_count_nxt;

    logic [31:0]  w_sel_pc;
    logic [31:0]  w_pc_plus4;
    npc_kind_e    w_kind;
    logic         w_illegal;

    pc_next_sel #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_pc_next_sel (
        .pc            (r_pc),
        .pc_region     (r_ifid_pc4[31:28]),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .stall         (stall),
        .next_pc       (w_sel_pc),
        .pc_plus4      (w_pc_plus4),
        .kind          (w_kind),
        .illegal       (w_illegal)
    );

    // Next-state and datapath update decisions; everything holds by default
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_ifid_instr_nxt  = r_ifid_instr;
        w_ifid_pc4_nxt    = r_ifid_pc4;
        w_ifid_valid_nxt  = r_ifid_valid;
        w_fault_nxt       = r_fault;
        w_fetch_count_nxt = r_fetch_count;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_illegal) begin
                    w_fault_nxt      = 1'b1;
                    w_state_nxt      = ST_HALT;
                    w_ifid_instr_nxt = NOP_INSTR;
                    w_ifid_pc4_nxt   = 32'h0;
                    w_ifid_valid_nxt = 1'b0;
                end else begin
                    case (w_kind)
                        NPC_SEQ: begin
                            w_pc_nxt          = w_sel_pc;
                            w_ifid_instr_nxt  = imem_instr;
                            w_ifid_pc4_nxt    = w_pc_plus4;
                            w_ifid_valid_nxt  = 1'b1;
                            w_fetch_count_nxt = r_fetch_count + 32'd1;
                        end
                        NPC_REDIRECT: begin
                            w_pc_nxt         = w_sel_pc;
                            w_ifid_instr_nxt = NOP_INSTR;
                            w_ifid_pc4_nxt   = 32'h0;
                            w_ifid_valid_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    // State and pipeline registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_pc4    <= 32'h0;
            r_ifid_valid  <= 1'b0;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_ifid_instr  <= w_ifid_instr_nxt;
            r_ifid_pc4    <= w_ifid_pc4_nxt;
            r_ifid_valid  <= w_ifid_valid_nxt;
            r_fault       <= w_fault_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_valid  = r_ifid_valid;
    assign fault       = r_fault;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
